// File: rtl/kpg_pkg.sv
// Shared constants and the buffered result record for the KPG sum stage.
package kpg_pkg;

  localparam logic [1:0] KPG_KILL  = 2'b00;
  localparam logic [1:0] KPG_GEN   = 2'b11;
  localparam int         KPG_WIDTH = 32;

  typedef struct packed {
    logic [KPG_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
  } kpg_res_t;

endpackage

// File: rtl/kpg_res_fifo2.sv
// Two-entry valid/ready result buffer; in_ready depends only on the count register.
module kpg_res_fifo2
  import kpg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  kpg_res_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output kpg_res_t out_data
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  kpg_res_t   mem_r [2];
  logic       head_r;
  logic       tail_r;
  logic [1:0] count_r;
  logic [1:0] count_nxt_s;
  logic       push_s;
  logic       pop_s;

  assign in_ready  = (count_r < FULL);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = mem_r[head_r];
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, 1-bit wrapping pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      head_r   <= 1'b0;
      tail_r   <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[tail_r] <= in_data;
        tail_r        <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/kpg_sum_stage.sv
// Sum/flag formation from resolved KPG carry codes, buffered behind valid/ready.
// Optional KPG_CHECK_EN adds a sticky kpg_err consistency checker.
module kpg_sum_stage
  import kpg_pkg::*;
#(
  parameter int WIDTH = KPG_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
`ifdef KPG_CHECK_EN
  ,
  output logic             kpg_err
`endif
);

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] cin_s;
  logic [WIDTH-1:0] sum_s;
  kpg_res_t         res_s;
  kpg_res_t         head_s;

  // r1[i] is the carry out of bit i, so bit i sees r1[i-1]; bit 0 has no carry-in.
  assign p_s   = a ^ b;
  assign cin_s = {r1[WIDTH-2:0], 1'b0};
  assign sum_s = p_s ^ cin_s;

  assign res_s.sum  = sum_s;
  assign res_s.cout = r1[WIDTH-1];
  assign res_s.ovf  = r1[WIDTH-1] ^ r1[WIDTH-2];
  assign res_s.zero = ~|sum_s;

  kpg_res_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_s)
  );

  assign sum  = head_s.sum;
  assign cout = head_s.cout;
  assign ovf  = head_s.ovf;
  assign zero = head_s.zero;

`ifdef KPG_CHECK_EN
  logic             err_r;
  logic [WIDTH-1:0] ref_sum_s;

  assign ref_sum_s = a + b;

  // Sticky flag: unresolved code or a sum that disagrees with a plain adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (in_valid && in_ready && ((r0 != r1) || (ref_sum_s != sum_s))) begin
      err_r <= 1'b1;
    end
  end

  assign kpg_err = err_r;
`else
  logic unused_r0;
  assign unused_r0 = &{1'b0, r0};
`endif

endmodule

// File: tb/tb_kpg_sum_stage.sv
// Directed self-checking bench for kpg_sum_stage (covers KPG_CHECK_EN when defined).
module tb_kpg_sum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, r0, r1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout, ovf, zero;
`ifdef KPG_CHECK_EN
  logic        kpg_err;
`endif

  int n_checks = 0;
  int n_miss   = 0;

  always #5 clk = ~clk;

  kpg_sum_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .r0        (r0),
    .r1        (r1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
`ifdef KPG_CHECK_EN
    ,
    .kpg_err   (kpg_err)
`endif
  );

  // Fully resolved carry codes: bit i = carry out of bit i of x+y.
  function automatic logic [31:0] codes(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] full;
    logic [31:0] cin;
    full = {1'b0, x} + {1'b0, y};
    cin  = x ^ y ^ full[31:0];
    return {full[32], cin[31:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y);
    a        = x;
    b        = y;
    r0       = codes(x, y);
    r1       = r0;
    in_valid = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] s,
                            input logic c, input logic o, input logic z);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   sum,            s);
    check({tag, "_flags"}, {29'd0, cout, ovf, zero}, {29'd0, c, o, z});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = 32'd0; b = 32'd0; r0 = 32'd0; r1 = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sum",       sum,            32'd0);
    check("rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1 + FFFFFFFF wraps to zero with carry out.
    out_ready = 1'b1;
    drive(32'h0000_0001, 32'hFFFF_FFFF);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("wrap_drained", 32'(out_valid), 32'd0);

    // Positive overflow into the sign bit.
    drive(32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Fill with out_ready low: X1 and X2 accepted, X3 held off.
    out_ready = 1'b0;
    drive(32'h0000_0005, 32'h0000_0003);
    @(negedge clk);
    check("fill1_in_ready", 32'(in_ready), 32'd1);
    drive(32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check_head("full_head", 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("held_in_ready", 32'(in_ready), 32'd0);
    check_head("held_head", 32'h0000_0008, 1'b0, 1'b0, 1'b0);

    // Drain: pop X1, then simultaneous pop X2 / push X3 at count 1.
    out_ready = 1'b1;
    @(negedge clk);
    check_head("x2", 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    check("x2_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("x3", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    check("x3_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with the buffer full.
    out_ready = 1'b0;
    drive(32'h0000_0005, 32'h0000_0003);
    @(negedge clk);
    drive(32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready",  32'(in_ready),  32'd1);
    check("async_sum",       sum,            32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Buffer still works after reset.
    out_ready = 1'b1;
    drive(32'h1234_5678, 32'h1111_1111);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("post_rst", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

`ifdef KPG_CHECK_EN
    check("err_clean", 32'(kpg_err), 32'd0);
    a = 32'd0; b = 32'd0; r0 = 32'h0000_0001; r1 = 32'h0000_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("err_set", 32'(kpg_err), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("err_sticky", 32'(kpg_err), 32'd1);
    rst = 1'b1;
    #1;
    check("err_rst", 32'(kpg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
